param_serializer: RTL and testbench

Parametrised parallel-to-serial transmitter with a programmable bit-rate divider, selectable bit order and a one-word holding register for back-to-back frames. It sits between a parallel word source and a two-wire serial link (`ser_clock`, `ser_data`) and generates the serial clock as a registered output on the single system `clock`. It is the next generation of the team's 8-bit serializer.

---
 rtl/param_serializer.sv | 191 +++++++++++++++++++
 tb/tb_param_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_serializer.sv
// Parallel-to-serial transmitter with programmable half-period divider,
// selectable bit order and a one-word holding register for gapless chaining.
module param_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     par_data,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 msb_first,
    input  logic                 store,
    output logic                 ser_clock,
    output logic                 ser_data,
    output logic                 ready,
    output logic                 empty,
    output logic                 done,
    output logic                 overrun
);

    localparam int unsigned BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t               r_state, w_state;
    logic [WIDTH-1:0]     r_shift, w_shift;
    logic                 r_msb, w_msb;
    logic [DIV_WIDTH-1:0] r_div, w_div;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
    logic [BCW-1:0]       r_bitcnt, w_bitcnt;
    logic                 r_sclk, w_sclk;
    logic                 r_sdata, w_sdata;
    logic                 r_hold_v, w_hold_v;
    logic [WIDTH-1:0]     r_hold_data, w_hold_data;
    logic [DIV_WIDTH-1:0] r_hold_div, w_hold_div;
    logic                 r_hold_msb, w_hold_msb;
    logic                 r_done, w_done;
    logic                 r_overrun, w_overrun;
    logic                 r_ready, w_ready;
    logic                 r_empty, w_empty;

    logic                 w_load;
    logic                 w_direct;
    logic [WIDTH-1:0]     w_ld_data;
    logic [DIV_WIDTH-1:0] w_ld_div;
    logic                 w_ld_msb;

    function automatic logic first_bit(input logic [WIDTH-1:0] d, input logic m);
        return m ? d[WIDTH-1] : d[0];
    endfunction

    // Next-state: bit timing, word hand-off and holding-register management
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_msb       = r_msb;
        w_div       = r_div;
        w_cnt       = r_cnt;
        w_bitcnt    = r_bitcnt;
        w_sclk      = r_sclk;
        w_sdata     = r_sdata;
        w_hold_v    = r_hold_v;
        w_hold_data = r_hold_data;
        w_hold_div  = r_hold_div;
        w_hold_msb  = r_hold_msb;
        w_done      = 1'b0;
        w_overrun   = r_overrun;
        w_load      = 1'b0;
        w_direct    = 1'b0;
        w_ld_data   = par_data;
        w_ld_div    = divider;
        w_ld_msb    = msb_first;

        case (r_state)
            S_IDLE: begin
                if (store) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - DIV_WIDTH'(1);
                end else begin
                    w_cnt  = r_div;
                    w_sclk = ~r_sclk;
                    if (r_sclk) begin
                        if (r_bitcnt == LAST_BIT) begin
                            w_done = 1'b1;
                            if (r_hold_v) begin
                                w_load    = 1'b1;
                                w_ld_data = r_hold_data;
                                w_ld_div  = r_hold_div;
                                w_ld_msb  = r_hold_msb;
                                w_hold_v  = 1'b0;
                            end else if (store) begin
                                w_load   = 1'b1;
                                w_direct = 1'b1;
                            end else begin
                                w_state = S_IDLE;
                                w_sdata = 1'b0;
                            end
                        end else begin
                            w_bitcnt = r_bitcnt + BCW'(1);
                            w_shift  = r_msb ? (r_shift << 1) : (r_shift >> 1);
                            w_sdata  = r_msb ? w_shift[WIDTH-1] : w_shift[0];
                        end
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // A load starts the low half of the first bit period
        if (w_load) begin
            w_state  = S_SHIFT;
            w_shift  = w_ld_data;
            w_div    = w_ld_div;
            w_msb    = w_ld_msb;
            w_cnt    = w_ld_div;
            w_bitcnt = '0;
            w_sclk   = 1'b0;
            w_sdata  = first_bit(w_ld_data, w_ld_msb);
        end

        if (store) begin
            if (r_hold_v) begin
                w_overrun = 1'b1;
            end else if ((r_state == S_SHIFT) && !w_direct) begin
                w_hold_v    = 1'b1;
                w_hold_data = par_data;
                w_hold_div  = divider;
                w_hold_msb  = msb_first;
            end
        end

        w_ready = !w_hold_v;
        w_empty = (w_state == S_IDLE) && !w_hold_v;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_msb       <= 1'b0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_sclk      <= 1'b0;
            r_sdata     <= 1'b0;
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_hold_div  <= '0;
            r_hold_msb  <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_ready     <= 1'b1;
            r_empty     <= 1'b1;
        end else begin
            r_state     <= w_state;
            r_shift     <= w_shift;
            r_msb       <= w_msb;
            r_div       <= w_div;
            r_cnt       <= w_cnt;
            r_bitcnt    <= w_bitcnt;
            r_sclk      <= w_sclk;
            r_sdata     <= w_sdata;
            r_hold_v    <= w_hold_v;
            r_hold_data <= w_hold_data;
            r_hold_div  <= w_hold_div;
            r_hold_msb  <= w_hold_msb;
            r_done      <= w_done;
            r_overrun   <= w_overrun;
            r_ready     <= w_ready;
            r_empty     <= w_empty;
        end
    end

    assign ser_clock = r_sclk;
    assign ser_data  = r_sdata;
    assign ready     = r_ready;
    assign empty     = r_empty;
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: table vectors, hand-written corner sequences and
// random stores, all checked cycle by cycle against a word-level timing model.
module tb_param_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [W-1:0]  par_data;
    logic [DW-1:0] divider;
    logic          msb_first;
    logic          store;
    logic          ser_clock, ser_data, ready, empty, done, overrun;

    param_serializer #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .par_data (par_data),
        .divider  (divider),
        .msb_first(msb_first),
        .store    (store),
        .ser_clock(ser_clock),
        .ser_data (ser_data),
        .ready    (ready),
        .empty    (empty),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        int           div;
        bit           msb;
    } word_t;

    typedef struct {
        logic [W-1:0] data;
        int           div;
        bit           msb;
        logic [W-1:0] seq;   // bits in transmission order, first sent at MSB
        int           len;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Word-level model: a word started at edge s with divider D is on the wire
    // for W*2*(D+1) edges; outputs derive from the phase within that window.
    bit    m_active = 0;
    int    m_start  = 0;
    int    m_len    = 0;
    word_t m_cur;
    bit    m_hold_v = 0;
    word_t m_hold;
    bit    m_overrun = 0;
    logic  e_sclk, e_sdata, e_ready, e_empty, e_done;

    logic [15:0] rx;
    int          rx_n = 0;
    logic        prev_sclk = 1'b0;
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_start_word(input word_t w);
        m_cur    = w;
        m_start  = t;
        m_len    = W * 2 * (w.div + 1);
        m_active = 1;
    endtask

    task automatic model_step();
        word_t in_w;
        bit    hv_pre;
        bit    final_edge;
        int    phase, hp, idx;
        in_w.data = par_data;
        in_w.div  = int'(divider);
        in_w.msb  = msb_first;
        e_done = 1'b0;
        if (!reset_n) begin
            m_active  = 0;
            m_hold_v  = 0;
            m_overrun = 0;
        end else begin
            hv_pre     = m_hold_v;
            final_edge = m_active && (t - m_start == m_len);
            if (store && hv_pre) m_overrun = 1;
            if (final_edge) begin
                e_done = 1'b1;
                if (hv_pre) begin
                    m_start_word(m_hold);
                    m_hold_v = 0;
                end else if (store) begin
                    m_start_word(in_w);
                end else begin
                    m_active = 0;
                end
            end else if (!m_active) begin
                if (store) m_start_word(in_w);
            end else if (store && !hv_pre) begin
                m_hold   = in_w;
                m_hold_v = 1;
            end
        end
        if (m_active) begin
            phase   = t - m_start;
            hp      = m_cur.div + 1;
            idx     = phase / (2 * hp);
            e_sclk  = ((phase / hp) % 2) == 1;
            e_sdata = m_cur.msb ? m_cur.data[W-1-idx] : m_cur.data[idx];
        end else begin
            e_sclk  = 1'b0;
            e_sdata = 1'b0;
        end
        e_ready = !m_hold_v;
        e_empty = !m_active && !m_hold_v;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        chk($sformatf("outputs@%0d", t),
            {26'd0, ser_clock, ser_data, ready, empty, done, overrun},
            {26'd0, e_sclk, e_sdata, e_ready, e_empty, e_done, m_overrun});
        if (!prev_sclk && ser_clock) begin
            rx = {rx[14:0], ser_data};
            rx_n++;
        end
        prev_sclk = ser_clock;
        if (done) done_cnt++;
        t++;
    endtask

    task automatic put(input logic [W-1:0] d, input int dv, input bit m);
        par_data  = d;
        divider   = DW'(dv);
        msb_first = m;
        store     = 1'b1;
    endtask

    task automatic wait_done(input int bound, output int edge_idx);
        int start_cnt;
        start_cnt = done_cnt;
        edge_idx  = -1;
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (done_cnt != start_cnt) begin
                edge_idx = t - 1;
                break;
            end
        end
        if (edge_idx < 0) chk("done_timeout", 32'd1, 32'd0);
    endtask

    vec_t vecs[5];
    int   t0, te, te2, dc;

    initial begin
        vecs[0] = '{8'hA5, 1, 1'b0, 8'hA5, 32};
        vecs[1] = '{8'h81, 0, 1'b1, 8'h81, 16};
        vecs[2] = '{8'h12, 0, 1'b0, 8'h48, 16};
        vecs[3] = '{8'h12, 3, 1'b1, 8'h12, 64};
        vecs[4] = '{8'h3C, 2, 1'b0, 8'h3C, 48};

        reset_n = 1'b0; store = 1'b0; par_data = '0; divider = '0; msb_first = 1'b0;
        rx = '0;
        cycle();
        cycle();
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        reset_n = 1'b1;
        cycle();

        // Single-word table
        for (int v = 0; v < 5; v++) begin
            rx = '0; rx_n = 0;
            put(vecs[v].data, vecs[v].div, vecs[v].msb);
            cycle();
            t0 = t - 1;
            store = 1'b0;
            wait_done(200, te);
            chk($sformatf("vec%0d_len", v), te - t0, vecs[v].len);
            chk($sformatf("vec%0d_bits", v), {24'd0, rx[7:0]}, {24'd0, vecs[v].seq});
            chk($sformatf("vec%0d_nbits", v), rx_n, 8);
            chk($sformatf("vec%0d_empty", v), {31'd0, empty}, 32'd1);
            cycle();
        end

        // Back-to-back: 0x0F then 0xF0, both LSB first
        rx = '0; rx_n = 0;
        put(8'h0F, 1, 1'b0);
        cycle();
        t0 = t - 1;
        store = 1'b0;
        repeat (9) cycle();
        put(8'hF0, 1, 1'b0);
        cycle();
        store = 1'b0;
        chk("b2b_ready_held", {31'd0, ready}, 32'd0);
        wait_done(200, te);
        wait_done(200, te2);
        chk("b2b_first_len", te - t0, 32);
        chk("b2b_total_len", te2 - t0, 64);
        chk("b2b_bits", {16'd0, rx}, 32'h0000F00F);
        chk("b2b_empty", {31'd0, empty}, 32'd1);
        cycle();

        // Overrun with holding register full
        rx = '0; rx_n = 0;
        put(8'h33, 0, 1'b1);
        cycle();
        store = 1'b0;
        repeat (3) cycle();
        put(8'hCC, 0, 1'b1);
        cycle();
        store = 1'b0;
        repeat (2) cycle();
        put(8'h55, 0, 1'b1);
        cycle();
        store = 1'b0;
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        wait_done(200, te);
        wait_done(200, te2);
        repeat (30) cycle();
        chk("ovr_bits", {16'd0, rx}, 32'h000033CC);
        chk("ovr_nbits", rx_n, 16);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        cycle();

        // Store exactly on the final falling edge with holding register free
        rx = '0; rx_n = 0;
        put(8'hC3, 0, 1'b0);
        cycle();
        t0 = t - 1;
        store = 1'b0;
        repeat (15) cycle();
        put(8'h5A, 0, 1'b0);
        cycle();
        store = 1'b0;
        chk("cc_done", {31'd0, done}, 32'd1);
        chk("cc_not_empty", {31'd0, empty}, 32'd0);
        chk("cc_first_bit", {30'd0, ser_clock, ser_data}, 32'd0);
        wait_done(200, te);
        chk("cc_total_len", te - t0, 32);
        chk("cc_bits", {16'd0, rx}, 32'h0000C35A);
        cycle();

        // Reset after three bits with a word waiting in the holding register
        put(8'hE7, 1, 1'b1);
        cycle();
        store = 1'b0;
        repeat (3) cycle();
        put(8'h18, 1, 1'b1);
        cycle();
        store = 1'b0;
        repeat (7) cycle();
        reset_n = 1'b0;
        cycle();
        chk("rst_sclk", {31'd0, ser_clock}, 32'd0);
        chk("rst_sdata", {31'd0, ser_data}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        dc = done_cnt;
        repeat (60) cycle();
        chk("rst_hold_discarded", done_cnt - dc, 0);

        // Random stores, occasional reset
        repeat (3000) begin
            store     = ($urandom_range(0, 9) == 0);
            par_data  = W'($urandom);
            divider   = DW'($urandom_range(0, 3));
            msb_first = $urandom_range(0, 1) == 1;
            reset_n   = ($urandom_range(0, 999) != 0);
            cycle();
        end
        store = 1'b0;
        reset_n = 1'b1;
        repeat (100) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
